// File: rtl/pixel_sink.sv
// rtl/pixel_sink.sv - pixel stream to 1-bit framebuffer plotter with display row-read port
// Build option: define PIXEL_XOR_EN to plot with XOR instead of OR.
module pixel_sink #(
    parameter int FB_W       = 32,
    parameter int FB_H       = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_valid,
    input  logic [7:0]              pix_x,
    input  logic [7:0]              pix_y,
    input  logic                    line_done,
    input  logic                    clear,
    input  logic [$clog2(FB_H)-1:0] rd_row,
    output logic [FB_W-1:0]         rd_data,
    output logic                    busy,
    output logic                    drained,
    output logic                    overflow,
    output logic [7:0]              clip_cnt
);
    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = XW + YW;
    localparam logic [8:0]  X_LIM    = 9'(FB_W);
    localparam logic [8:0]  Y_LIM    = 9'(FB_H);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [YW-1:0] LAST_ROW = YW'(FB_H - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

    state_t          state;
    logic [FB_W-1:0] fb [FB_H];
    logic [FB_W-1:0] word;
    logic [XW-1:0]   px;
    logic [YW-1:0]   py;
    logic [YW-1:0]   clr_row;
    logic            clear_pending;
    logic            done_seen;

    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;

    logic            fifo_empty, fifo_full, go_clr, pop, in_range, intake, push;
    logic [XW-1:0]   head_x;
    logic [YW-1:0]   head_y;
    logic [FB_W-1:0] mask, plotted;

    always_comb begin
        fifo_empty       = (count == '0);
        fifo_full        = (count == CNT_FULL);
        go_clr           = clear_pending && (state == IDLE || state == WR);
        pop              = !go_clr && !fifo_empty && (state == IDLE || state == WR);
        // Range check uses the full 8-bit coordinates, before truncation to index width.
        in_range         = ({1'b0, pix_x} < X_LIM) && ({1'b0, pix_y} < Y_LIM);
        intake           = pix_valid && (state != CLR) && !go_clr;
        push             = intake && in_range && !fifo_full;
        {head_x, head_y} = fifo_mem[rd_ptr];
        mask             = {{(FB_W-1){1'b0}}, 1'b1} << px;
`ifdef PIXEL_XOR_EN
        plotted          = word ^ mask;
`else
        plotted          = word | mask;
`endif
    end

    assign busy    = !fifo_empty || (state != IDLE);
    assign drained = done_seen && fifo_empty && (state == IDLE);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {pix_x[XW-1:0], pix_y[YW-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            clip_cnt <= 8'd0;
        end else if (go_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            clip_cnt <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (intake && !in_range && clip_cnt != 8'hFF) clip_cnt <= clip_cnt + 8'd1;
            if (intake && in_range && fifo_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            done_seen     <= 1'b0;
            word          <= '0;
            px            <= '0;
            py            <= '0;
            clr_row       <= '0;
            rd_data       <= '0;
            for (int i = 0; i < FB_H; i++) fb[i] <= '0;
        end else begin
            rd_data <= fb[rd_row];

            if (go_clr)                         clear_pending <= 1'b0;
            else if (clear && state != CLR)     clear_pending <= 1'b1;

            if (go_clr)         done_seen <= 1'b0;
            else if (line_done) done_seen <= 1'b1;
            else if (drained)   done_seen <= 1'b0;

            case (state)
                IDLE: begin
                    if (go_clr) begin
                        state   <= CLR;
                        clr_row <= '0;
                    end else if (pop) begin
                        px    <= head_x;
                        py    <= head_y;
                        state <= RD;
                    end
                end
                RD: begin
                    word  <= fb[py];
                    state <= WR;
                end
                WR: begin
                    // The write lands before any following RD, so same-row pixels stay coherent.
                    fb[py] <= plotted;
                    if (go_clr) begin
                        state   <= CLR;
                        clr_row <= '0;
                    end else if (pop) begin
                        px    <= head_x;
                        py    <= head_y;
                        state <= RD;
                    end else begin
                        state <= IDLE;
                    end
                end
                CLR: begin
                    fb[clr_row] <= '0;
                    clr_row     <= clr_row + 1'b1;
                    if (clr_row == LAST_ROW) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_sink.sv
// tb/tb_pixel_sink.sv - scoreboard bench for pixel_sink with an occupancy/accept model
`timescale 1ns/1ps
module tb_pixel_sink;
    localparam int FB_W  = 32;
    localparam int FB_H  = 32;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic        line_done;
    logic        clear;
    logic [4:0]  rd_row;
    logic [31:0] rd_data;
    logic        busy;
    logic        drained;
    logic        overflow;
    logic [7:0]  clip_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          row;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_fb [FB_H];
    int          m_cnt;
    int          m_ph;

    always #5 clk = ~clk;

    pixel_sink #(.FB_W(FB_W), .FB_H(FB_H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .line_done(line_done), .clear(clear), .rd_row(rd_row), .rd_data(rd_data),
        .busy(busy), .drained(drained), .overflow(overflow), .clip_cnt(clip_cnt)
    );

    task automatic model_reset();
        for (int i = 0; i < FB_H; i++) m_fb[i] = 32'd0;
        m_cnt = 0;
        m_ph  = 0;
    endtask

    // One clock of stimulus; the model tracks FIFO occupancy and engine phase (0 idle, 1 rd, 2 wr).
    task automatic drive_cycle(input logic v, input int x, input int y);
        logic acc, pp;
        pix_valid = v;
        pix_x     = 8'(x);
        pix_y     = 8'(y);
        acc = v && (x < FB_W) && (y < FB_H) && (m_cnt < DEPTH);
        pp  = (m_cnt > 0) && (m_ph == 0 || m_ph == 2);
        if (acc) begin
`ifdef PIXEL_XOR_EN
            m_fb[y] = m_fb[y] ^ (32'd1 << x);
`else
            m_fb[y] = m_fb[y] | (32'd1 << x);
`endif
        end
        m_ph  = (m_ph == 1) ? 2 : (pp ? 1 : 0);
        m_cnt = m_cnt + int'(acc) - int'(pp);
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic read_row(input int row, output logic [31:0] d);
        rd_row = 5'(row);
        drive_cycle(1'b0, 0, 0);
        d = rd_data;
    endtask

    task automatic push_row(input int row);
        exp_t e;
        e.row = row;
        e.val = m_fb[row];
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            drive_cycle(1'b0, 0, 0);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b expected 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] d;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (drained !== 1'b0)  begin errors++; $display("FAIL reset_drained: got %b expected 0", drained); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (clip_cnt !== 8'd0) begin errors++; $display("FAIL reset_clip: got %0d expected 0", clip_cnt); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        rst = 1'b0;
        drive_cycle(1'b0, 0, 0);
        push_row(0);
        push_row(31);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_row(e.row, d);
            checks++;
            if (d !== e.val) begin errors++; $display("FAIL reset_row%0d: got %h expected %h", e.row, d, e.val); end
        end
    endtask

    task automatic test_stream();
        exp_t e;
        logic [31:0] d;
        int pulses = 0;
        drive_cycle(1'b1, 3, 0);
        drive_cycle(1'b1, 4, 1);
        drive_cycle(1'b1, 5, 2);
        line_done = 1'b1;
        drive_cycle(1'b0, 0, 0);
        line_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (drained) begin
                pulses++;
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_at_drained: got %b expected 0", busy); end
            end
            drive_cycle(1'b0, 0, 0);
        end
        checks++; if (pulses !== 1)      begin errors++; $display("FAIL stream_drained_pulses: got %0d expected 1", pulses); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL stream_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow: got %b expected 0", overflow); end
        push_row(0);
        push_row(1);
        push_row(2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_row(e.row, d);
            checks++;
            if (d !== e.val) begin errors++; $display("FAIL stream_row%0d: got %h expected %h", e.row, d, e.val); end
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        logic [31:0] d;
        for (int x = 0; x < 20; x++) drive_cycle(1'b1, x, 7);
        wait_idle("overflow");
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b expected 1", overflow); end
        push_row(7);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_row(e.row, d);
            checks++;
            if (d !== e.val) begin errors++; $display("FAIL overflow_row%0d: got %h expected %h", e.row, d, e.val); end
        end
    endtask

    task automatic test_clip();
        exp_t e;
        logic [31:0] d;
        drive_cycle(1'b1, 40, 2);
        drive_cycle(1'b1, 2, 40);
        drive_cycle(1'b0, 0, 0);
        checks++; if (clip_cnt !== 8'd2) begin errors++; $display("FAIL clip_count: got %0d expected 2", clip_cnt); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL clip_no_push: busy=%b expected 0", busy); end
        push_row(2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_row(e.row, d);
            checks++;
            if (d !== e.val) begin errors++; $display("FAIL clip_row%0d: got %h expected %h", e.row, d, e.val); end
        end
    endtask

    task automatic test_clear();
        exp_t e;
        logic [31:0] d;
        int n;
        for (int y = 0; y < FB_H; y++) begin
            for (int x = 0; x < FB_W; x++) begin
                drive_cycle(1'b1, x, y);
                drive_cycle(1'b0, 0, 0);
            end
        end
        wait_idle("fill");
        push_row(0);
        push_row(31);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_row(e.row, d);
            checks++;
            if (d !== e.val) begin errors++; $display("FAIL fill_row%0d: got %h expected %h", e.row, d, e.val); end
        end
        drive_cycle(1'b1, 0, 0);
        drive_cycle(1'b0, 0, 0);
        clear = 1'b1;
        drive_cycle(1'b0, 0, 0);
        clear = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            pix_valid = 1'b1;
            pix_x     = 8'((n * 7) % 40);
            pix_y     = 8'((n * 3) % 40);
            clear     = (n == 10);
            @(posedge clk); #1;
            n++;
        end
        pix_valid = 1'b0;
        clear     = 1'b0;
        checks++; if (n !== 33) begin errors++; $display("FAIL clear_busy_cycles: got %0d expected 33", n); end
        model_reset();
        drive_cycle(1'b0, 0, 0);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL clear_busy_after: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow: got %b expected 0", overflow); end
        checks++; if (clip_cnt !== 8'd0) begin errors++; $display("FAIL clear_clip: got %0d expected 0", clip_cnt); end
        for (int r = 0; r < FB_H; r++) push_row(r);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_row(e.row, d);
            checks++;
            if (d !== e.val) begin errors++; $display("FAIL clear_row%0d: got %h expected %h", e.row, d, e.val); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] d;
        rd_row = 5'd1;
        drive_cycle(1'b1, 50, 50);
        for (int i = 1; i <= 5; i++) drive_cycle(1'b1, i, i);
        checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        checks++; if (rd_data !== 32'h2)    begin errors++; $display("FAIL mid_row1_before: got %h expected 00000002", rd_data); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        checks++; if (drained !== 1'b0)  begin errors++; $display("FAIL mid_rst_drained: got %b expected 0", drained); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_overflow: got %b expected 0", overflow); end
        checks++; if (clip_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_clip: got %0d expected 0", clip_cnt); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL mid_rst_rd_data: got %h expected 0", rd_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        drive_cycle(1'b0, 0, 0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
        for (int r = 1; r <= 5; r++) push_row(r);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            read_row(e.row, d);
            checks++;
            if (d !== e.val) begin errors++; $display("FAIL mid_row%0d: got %h expected %h", e.row, d, e.val); end
        end
    endtask

    task automatic test_plot_twice();
        logic [31:0] d;
        logic [31:0] want;
`ifdef PIXEL_XOR_EN
        want = 32'h0;
`else
        want = 32'h200;
`endif
        drive_cycle(1'b1, 9, 5);
        drive_cycle(1'b1, 9, 5);
        wait_idle("twice");
        read_row(5, d);
        checks++;
        if (d !== want) begin errors++; $display("FAIL twice_row5: got %h expected %h", d, want); end
    endtask

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_x     = 8'd0;
        pix_y     = 8'd0;
        line_done = 1'b0;
        clear     = 1'b0;
        rd_row    = 5'd0;
        model_reset();
        test_reset();
        test_stream();
        test_overflow();
        test_clip();
        test_clear();
        test_reset_mid();
        test_plot_twice();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
